// File: rtl/weight_fetch.sv
// Read sequencer between the weight/feature ROM and the PE array: issues sequential
// ROM reads, packs returned words into LANES-wide vectors and streams them out.
module weight_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 256,
    parameter int LANES      = 4,
    parameter int LEN_WIDTH  = 16,
    localparam int AW        = $clog2(DATA_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [AW-1:0]               base_addr_i,
    input  logic [LEN_WIDTH-1:0]        num_words_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        rom_csen_o,
    output logic [AW-1:0]               rom_addr_o,
    input  logic [DATA_WIDTH-1:0]       rom_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*DATA_WIDTH-1:0] out_data_o,
    output logic [LANES-1:0]            out_mask_o,
    output logic                        out_last_o
);

    localparam int VW  = LANES * DATA_WIDTH;
    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          base_q, base_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   k_q, k_d;
    logic [1:0]             committed_q, committed_d;
    logic [VW-1:0]          pack_q, pack_d;

    logic                   cap_valid_q;
    logic                   cap_complete_q;
    logic                   cap_last_q;
    logic [LIW-1:0]         cap_lane_q;

    logic [VW-1:0]          fifo_data_q [2];
    logic [LANES-1:0]       fifo_mask_q [2];
    logic [1:0]             fifo_last_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             fifo_count_q;

    logic [LIW-1:0]         lane_k;
    logic                   final_word;
    logic                   completing;
    logic                   pop;
    logic                   stall;
    logic                   issue;
    logic                   push;
    logic [VW-1:0]          push_data;
    logic [LANES-1:0]       push_mask;

    assign lane_k     = LIW'(k_q % LEN_WIDTH'(LANES));
    assign final_word = (k_q == len_q - LEN_WIDTH'(1));
    assign completing = (lane_k == LIW'(LANES - 1)) || final_word;
    assign pop        = out_valid_o && out_ready_i;
    // A vector-completing read needs a guaranteed FIFO slot when its data returns.
    assign stall      = completing && (committed_q == 2'd2) && !pop;
    assign issue      = (state_q == FETCH) && !stall;
    assign push       = cap_valid_q && cap_complete_q;

    assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign rom_csen_o  = issue;
    assign rom_addr_o  = base_q + AW'(k_q);

    assign out_valid_o = (fifo_count_q != 2'd0);
    assign out_data_o  = fifo_data_q[rd_ptr_q];
    assign out_mask_o  = fifo_mask_q[rd_ptr_q];
    assign out_last_o  = fifo_last_q[rd_ptr_q];

    // The returning word is merged straight into the outgoing vector so a completed
    // vector reaches the FIFO on the same edge that would otherwise capture it.
    always_comb begin
        push_data = pack_q;
        push_data[cap_lane_q*DATA_WIDTH +: DATA_WIDTH] = rom_data_i;
        push_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            push_mask[i] = (i <= int'(cap_lane_q));
        end
        pack_d = pack_q;
        if (cap_valid_q) begin
            pack_d = cap_complete_q ? '0 : push_data;
        end
        committed_d = committed_q + {1'b0, issue && completing} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    len_d   = num_words_i;
                    k_d     = '0;
                    state_d = (num_words_i == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    k_d = k_q + LEN_WIDTH'(1);
                    if (final_word) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last_o) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            base_q         <= '0;
            len_q          <= '0;
            k_q            <= '0;
            committed_q    <= '0;
            pack_q         <= '0;
            cap_valid_q    <= 1'b0;
            cap_complete_q <= 1'b0;
            cap_last_q     <= 1'b0;
            cap_lane_q     <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            len_q          <= len_d;
            k_q            <= k_d;
            committed_q    <= committed_d;
            pack_q         <= pack_d;
            cap_valid_q    <= issue;
            cap_complete_q <= completing;
            cap_last_q     <= final_word;
            cap_lane_q     <= lane_k;
        end
    end

    // Two-entry output FIFO; the credit counter guarantees a push never finds it full.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_mask_q[i] <= '0;
            end
            fifo_last_q  <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= push_data;
                fifo_mask_q[wr_ptr_q] <= push_mask;
                fifo_last_q[wr_ptr_q] <= cap_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_count_q <= fifo_count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// Scoreboard bench for weight_fetch: expected addresses and vectors are queued at
// request time and compared as the DUT issues reads and hands off vectors.
module tb_weight_fetch;

    localparam int DW    = 8;
    localparam int LANES = 4;
    localparam int AW    = 8;
    localparam int LW    = 16;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   baseAddr;
    logic [LW-1:0]   numWords;
    logic            busy;
    logic            done;
    logic            romCsen;
    logic [AW-1:0]   romAddr;
    logic [DW-1:0]   romData;
    logic            outValid;
    logic            outReady;
    logic [31:0]     outData;
    logic [3:0]      outMask;
    logic            outLast;

    logic [7:0]      romMem [256];
    vec_t            expVec [$];
    logic [7:0]      expAddr [$];

    int totalChecks = 0;
    int failCount   = 0;
    int cyc         = 0;

    int startCyc   = 0;
    int firstCsen  = -1;
    int lastCsen   = -1;
    int csenCount  = 0;
    int firstValid = -1;
    int doneCyc    = -1;
    int doneCount  = 0;

    logic        heldValid = 1'b0;
    logic [31:0] heldData;
    logic [3:0]  heldMask;
    logic        heldLast;
    vec_t        ev;
    logic [7:0]  ea;

    weight_fetch #(
        .DATA_WIDTH(DW),
        .DATA_DEPTH(256),
        .LANES(LANES),
        .LEN_WIDTH(LW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .base_addr_i(baseAddr),
        .num_words_i(numWords),
        .busy_o(busy),
        .done_o(done),
        .rom_csen_o(romCsen),
        .rom_addr_o(romAddr),
        .rom_data_i(romData),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_data_o(outData),
        .out_mask_o(outMask),
        .out_last_o(outLast)
    );

    always #5 clk = ~clk;

    // Registered-read ROM; drives garbage whenever no read was issued.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        romData <= romCsen ? romMem[romAddr] : 8'($urandom);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart(input logic [7:0] base, input int n);
        @(posedge clk);
        #1;
        start    = 1'b1;
        baseAddr = base;
        numWords = LW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] base, input int n);
        vec_t       cur;
        logic [7:0] a;
        int         lane;
        cur.data = '0;
        cur.mask = '0;
        cur.last = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            expAddr.push_back(a);
            lane = i % LANES;
            cur.data[lane*8 +: 8] = romMem[a];
            cur.mask[lane] = 1'b1;
            if (lane == LANES - 1 || i == n - 1) begin
                cur.last = (i == n - 1);
                expVec.push_back(cur);
                cur.data = '0;
                cur.mask = '0;
                cur.last = 1'b0;
            end
        end
        pulseStart(base, n);
    endtask

    task automatic waitDone(input int maxCycles, input string tag);
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            #1;
            if (doneCount != 0) break;
        end
        checkOutput({tag, "_done_seen"}, 64'(doneCount), 64'd1);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_vec_left"}, 64'(expVec.size()), 64'd0);
        checkOutput({tag, "_addr_left"}, 64'(expAddr.size()), 64'd0);
    endtask

    // Monitor: address and vector scoreboard, hold stability, per-request timing.
    always @(negedge clk) begin
        if (rst) begin
            heldValid = 1'b0;
        end else begin
            if (start && !busy && !done) begin
                startCyc   = cyc;
                firstCsen  = -1;
                lastCsen   = -1;
                csenCount  = 0;
                firstValid = -1;
                doneCyc    = -1;
                doneCount  = 0;
            end
            if (heldValid) begin
                checkOutput("hold_valid", 64'(outValid), 64'd1);
                checkOutput("hold_data", 64'(outData), 64'(heldData));
                checkOutput("hold_mask", 64'(outMask), 64'(heldMask));
                checkOutput("hold_last", 64'(outLast), 64'(heldLast));
            end
            heldValid = outValid && !outReady;
            heldData  = outData;
            heldMask  = outMask;
            heldLast  = outLast;
            if (romCsen) begin
                if (firstCsen < 0) firstCsen = cyc - startCyc;
                lastCsen = cyc - startCyc;
                csenCount++;
                checkOutput("addr_expected", 64'(expAddr.size() != 0), 64'd1);
                if (expAddr.size() != 0) begin
                    ea = expAddr.pop_front();
                    checkOutput("rom_addr", 64'(romAddr), 64'(ea));
                end
            end
            if (outValid && firstValid < 0) firstValid = cyc - startCyc;
            if (outValid && outReady) begin
                checkOutput("vec_expected", 64'(expVec.size() != 0), 64'd1);
                if (expVec.size() != 0) begin
                    ev = expVec.pop_front();
                    checkOutput("out_data", 64'(outData), 64'(ev.data));
                    checkOutput("out_mask", 64'(outMask), 64'(ev.mask));
                    checkOutput("out_last", 64'(outLast), 64'(ev.last));
                end
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc - startCyc;
            end
            if (dut.push) checkOutput("push_into_full", 64'(dut.fifo_count_q == 2'd2), 64'd0);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) romMem[i] = 8'(i);
        rst      = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        numWords = '0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_csen", 64'(romCsen), 64'd0);
        checkOutput("rst_addr", 64'(romAddr), 64'd0);
        checkOutput("rst_valid", 64'(outValid), 64'd0);
        checkOutput("rst_data", 64'(outData), 64'd0);
        checkOutput("rst_mask", 64'(outMask), 64'd0);
        checkOutput("rst_last", 64'(outLast), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic transfer");
        applyStimulus(8'h10, 8);
        waitDone(100, "basic");
        checkOutput("basic_first_csen", 64'(firstCsen), 64'd1);
        checkOutput("basic_last_csen", 64'(lastCsen), 64'd8);
        checkOutput("basic_csen_count", 64'(csenCount), 64'd8);
        checkOutput("basic_first_valid", 64'(firstValid), 64'd6);
        checkOutput("basic_done_cyc", 64'(doneCyc), 64'd11);
        checkDrained("basic");
        // start in the done cycle must be ignored
        start    = 1'b1;
        baseAddr = 8'h55;
        numWords = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("done_start_busy", 64'(busy), 64'd0);
        checkOutput("done_start_csen", 64'(romCsen), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("basic_done_once", 64'(doneCount), 64'd1);

        $display("[TB] partial vector");
        applyStimulus(8'h10, 6);
        waitDone(100, "partial");
        checkOutput("partial_csen_count", 64'(csenCount), 64'd6);
        checkDrained("partial");

        $display("[TB] wrap-around");
        applyStimulus(8'hFE, 4);
        waitDone(100, "wrap");
        checkOutput("wrap_csen_count", 64'(csenCount), 64'd4);
        checkDrained("wrap");

        $display("[TB] start while busy");
        applyStimulus(8'h30, 8);
        pulseStart(8'h80, 5);
        waitDone(100, "busy_start");
        checkOutput("busy_start_csen_count", 64'(csenCount), 64'd8);
        checkDrained("busy_start");

        $display("[TB] zero length");
        applyStimulus(8'h00, 0);
        waitDone(10, "zero");
        checkOutput("zero_done_cyc", 64'((doneCyc == 1) || (doneCyc == 2)), 64'd1);
        checkOutput("zero_csen_count", 64'(csenCount), 64'd0);
        checkOutput("zero_no_valid", 64'(firstValid < 0), 64'd1);

        $display("[TB] backpressure");
        outReady = 1'b0;
        applyStimulus(8'h40, 32);
        repeat (19) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_stalled_csen_count", 64'(csenCount), 64'd11);
        checkOutput("bp_valid_waiting", 64'(outValid), 64'd1);
        checkOutput("bp_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            outReady = 1'($urandom_range(0, 1));
            if (doneCount != 0) break;
        end
        checkOutput("bp_done_seen", 64'(doneCount), 64'd1);
        checkOutput("bp_csen_count", 64'(csenCount), 64'd32);
        outReady = 1'b1;
        checkDrained("bp");

        $display("[TB] reset mid-transfer");
        repeat (2) @(posedge clk);
        outReady = 1'b0;
        applyStimulus(8'h60, 16);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (outValid) break;
        end
        checkOutput("mid_vec_present", 64'(outValid), 64'd1);
        checkOutput("mid_busy", 64'(busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_done", 64'(done), 64'd0);
        checkOutput("mid_rst_csen", 64'(romCsen), 64'd0);
        checkOutput("mid_rst_addr", 64'(romAddr), 64'd0);
        checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
        checkOutput("mid_rst_data", 64'(outData), 64'd0);
        checkOutput("mid_rst_mask", 64'(outMask), 64'd0);
        checkOutput("mid_rst_last", 64'(outLast), 64'd0);
        expVec.delete();
        expAddr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_no_done", 64'(doneCount), 64'd0);
        checkOutput("mid_idle_valid", 64'(outValid), 64'd0);
        outReady = 1'b1;
        applyStimulus(8'h20, 4);
        waitDone(100, "post_rst");
        checkOutput("post_rst_csen_count", 64'(csenCount), 64'd4);
        checkDrained("post_rst");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, failCount);
        $finish;
    end

endmodule
